// File: rtl/mix_cols_iter.sv
// Iterative AES MixColumns engine: mixes COLS_PER_CYC columns per clock with valid/ready on both sides.
// Define MIX_COLS_ITER_INV_EN to build the InvMixColumns network; otherwise the block is forward-only.
module mix_cols_iter #(
    parameter int COLS_PER_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);
    localparam int NCYC = 4 / COLS_PER_CYC;
    localparam logic [1:0] LAST_GRP = 2'((NCYC - 1) * COLS_PER_CYC);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYC);

    generate
        if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
            $error("mix_cols_iter: COLS_PER_CYC must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    logic [1:0]          r_col_cnt;
    logic [0:3][31:0]    r_work;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [1:0]          w_idx   [COLS_PER_CYC];
    logic [31:0]         w_mixed [COLS_PER_CYC];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] o [4];
        for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
        for (int r = 0; r < 4; r++)
            o[r] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        return {o[0], o[1], o[2], o[3]};
    endfunction

`ifdef MIX_COLS_ITER_INV_EN
    logic r_inv;

    // Inverse coefficients built from the x2/x4/x8 chain of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] o [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2    = xt(a[r]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++)
            o[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        return {o[0], o[1], o[2], o[3]};
    endfunction
`else
    logic w_unused_inv;
    assign w_unused_inv = inv;
`endif

    generate
        for (genvar gi = 0; gi < COLS_PER_CYC; gi++) begin : g_col
            assign w_idx[gi] = r_col_cnt + 2'(gi);
`ifdef MIX_COLS_ITER_INV_EN
            assign w_mixed[gi] = r_inv ? mix_inv(r_work[w_idx[gi]]) : mix_fwd(r_work[w_idx[gi]]);
`else
            assign w_mixed[gi] = mix_fwd(r_work[w_idx[gi]]);
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col_cnt   <= 2'd0;
            r_work      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef MIX_COLS_ITER_INV_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work     <= din;
                        r_col_cnt  <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_BUSY;
`ifdef MIX_COLS_ITER_INV_EN
                        r_inv      <= inv;
`endif
                    end
                end
                S_BUSY: begin
                    for (int i = 0; i < COLS_PER_CYC; i++) r_work[w_idx[i]] <= w_mixed[i];
                    r_col_cnt <= r_col_cnt + COL_STEP;
                    if (r_col_cnt == LAST_GRP) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_work;
endmodule

// File: tb/tb_mix_cols_iter.sv
// Self-checking bench for mix_cols_iter: one instance per legal COLS_PER_CYC, checked against a GF(2^8) matrix model.
module tb_mix_cols_iter;
`ifdef MIX_COLS_ITER_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] din       [3];
    logic         inv_i     [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] dout      [3];

    int total = 0;
    int bad   = 0;

    generate
        for (genvar gk = 0; gk < 3; gk++) begin : g_dut
            mix_cols_iter #(.COLS_PER_CYC(1 << gk)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[gk]),
                .in_ready  (in_ready[gk]),
                .din       (din[gk]),
                .inv       (inv_i[gk]),
                .out_valid (out_valid[gk]),
                .out_ready (out_ready[gk]),
                .dout      (dout[gk])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: generic GF(2^8) multiply and the MixColumns circulant matrix.
    function automatic bit [7:0] gmul(bit [7:0] a, bit [7:0] b);
        bit [7:0] p = 8'h00;
        bit hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic bit [127:0] ref_mix(bit [127:0] s, bit iv);
        bit [7:0] fwd_c [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        bit [7:0] inv_c [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        bit [127:0] res = '0;
        bit [7:0] acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(iv ? inv_c[(j-r+4)%4] : fwd_c[(j-r+4)%4], s[127-8*(4*c+j) -: 8]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        return res;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One transaction on instance k with out_ready held high; checks latency, result and release.
    task automatic txn(int k, bit [127:0] d, bit iv, bit [127:0] exp, string nm);
        int cyc = 0;
        @(negedge clk);
        chk({nm, " in_ready before accept"}, in_ready[k], 1);
        din[k] = d; inv_i[k] = iv; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        din[k] = ~d; inv_i[k] = ~iv;
        while (!out_valid[k] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " latency"}, cyc, 4 >> k);
        chk({nm, " dout"}, dout[k], exp);
        $display("txn cpc=%0d inv=%0d din=%h dout=%h lat=%0d", 1 << k, iv, d, dout[k], cyc);
        @(posedge clk); #1;
        chk({nm, " out_valid after handshake"}, out_valid[k], 0);
        chk({nm, " in_ready after handshake"}, in_ready[k], 1);
    endtask

    typedef struct {
        bit [127:0] din;
        bit         inv;
        bit [127:0] exp;
    } vec_t;

    initial begin
        vec_t tbl [4];
        bit [127:0] d;
        bit [127:0] exp_bp;
        bit seen;
        int cyc;

        tbl[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
        tbl[1] = '{128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6};
        tbl[2] = '{128'hd4d4d4d52d26314cdb13534501010101, 1'b0, 128'hd5d5d7d64d7ebdf88e4da1bc01010101};
        tbl[3] = '{128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
                   INV_EN ? 128'hd4bf5d30e0b452aeb84111f11e2798e5
                          : ref_mix(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0)};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; din[k] = '0; inv_i[k] = 1'b0; out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset in_ready k%0d", k), in_ready[k], 1);
            chk($sformatf("reset out_valid k%0d", k), out_valid[k], 0);
            chk($sformatf("reset dout k%0d", k), dout[k], 0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++)
                txn(k, tbl[v].din, tbl[v].inv, tbl[v].exp, $sformatf("vec%0d k%0d", v, k));

        // Backpressure on COLS_PER_CYC=1: result must hold while upstream pushes ignored data.
        @(negedge clk);
        din[0] = tbl[0].din; inv_i[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        exp_bp = tbl[0].exp;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        cyc = 0;
        while (!out_valid[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp latency", cyc, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            din[0] = {$urandom, $urandom, $urandom, $urandom};
            inv_i[0] = i[0];
            @(posedge clk); #1;
            chk($sformatf("bp hold out_valid %0d", i), out_valid[0], 1);
            chk($sformatf("bp hold dout %0d", i), dout[0], exp_bp);
            chk($sformatf("bp hold in_ready %0d", i), in_ready[0], 0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", out_valid[0], 0);
        chk("bp release in_ready", in_ready[0], 1);
        $display("txn cpc=1 backpressure dout=%h", exp_bp);

        // Reset in the second BUSY cycle discards the partial result.
        @(negedge clk);
        din[0] = tbl[1].din; inv_i[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready[0], 1);
        chk("midrst out_valid", out_valid[0], 0);
        chk("midrst dout", dout[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        chk("midrst no out_valid", seen, 0);
        $display("txn cpc=1 mid-operation reset");
        txn(0, tbl[2].din, 1'b0, tbl[2].exp, "post-reset");

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                txn(k, d, i[0], ref_mix(d, i[0] && INV_EN), $sformatf("rand%0d k%0d", i, k));
            end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
